// File: rtl/alm_dot_accumulator.sv
// Accumulates a programmable-length stream of signed 32-bit products into one
// signed dot-product result, with optional saturation and a sticky overflow flag.
module alm_dot_accumulator #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [31:0]      p_data,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_ovf,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [LEN_W:0]   CNT_ONE = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W:0]   r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic             r_ovf;

  logic             w_p_ready;
  logic             w_accept;
  logic [LEN_W-1:0] w_len_eff;
  logic [ACC_W-1:0] w_p_sext;
  logic [ACC_W:0]   w_sum;
  logic             w_sum_ovf;
  logic [ACC_W-1:0] w_acc_next;
  logic [LEN_W:0]   w_cnt_inc;

  // NOTE: rst_n gates p_ready combinationally so no product is taken while the
  // async reset is asserted, even before the registers have been cleared.
  assign w_p_ready = ((r_state == S_IDLE) || (r_state == S_ACCUM)) && rst_n && !clear;
  assign w_accept  = p_valid && w_p_ready;
  assign w_len_eff = (len == '0) ? LEN_ONE : len;
  assign w_p_sext  = {{(ACC_W-32){p_data[31]}}, p_data};
  assign w_cnt_inc = r_cnt + CNT_ONE;

  // One guard bit is enough: a 32-bit term can push the sum past only one bound.
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-31){p_data[31]}}, p_data};
  assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
    if (SAT && w_sum_ovf) begin
      w_acc_next = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len_q <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= w_p_sext;
            r_cnt   <= CNT_ONE;
            r_len_q <= w_len_eff;
            r_ovf   <= 1'b0;
            r_state <= (w_len_eff == LEN_ONE) ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_sum_ovf;
            if (w_cnt_inc == {1'b0, r_len_q}) begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (acc_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p_ready   = w_p_ready;
  assign acc_valid = (r_state == S_HOLD);
  assign acc_data  = r_acc;
  assign acc_ovf   = r_ovf;
  assign busy      = (r_state != S_IDLE);

endmodule
